// File: rtl/demux_dispatch_ctrl.sv
// Sequencer for the 1-to-3 data demux: registers upstream words with a lane select,
// assigning WORDS_PER_LANE-word blocks to lanes 0,1,2 for cfg_groups rounds.
module demux_dispatch_ctrl #(
   parameter int DATA_W         = 64,
   parameter int WORDS_PER_LANE = 9
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [7:0]        cfg_groups,
   input  logic              in_valid,
   input  logic [DATA_W-1:0] in_data,
   output logic              in_ready,
   input  logic [2:0]        lane_ready,
   output logic [DATA_W-1:0] Data_out,
   output logic [1:0]        sel,
   output logic              out_valid,
   output logic              busy,
   output logic              done
);

   localparam int WC_W = (WORDS_PER_LANE > 1) ? $clog2(WORDS_PER_LANE) : 1;
   localparam logic [WC_W-1:0] WORD_LAST = WC_W'(WORDS_PER_LANE - 1);

   typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;

   state_t          state, state_nxt;
   logic [WC_W-1:0] word_cnt;
   logic [1:0]      lane_cnt;
   logic [7:0]      group_cnt;
   logic [7:0]      groups_q;
   logic            sel_ready;
   logic            drain;
   logic            accept;
   logic            last_word;

   // sel==3 means no word is held, so nothing can drain
   always_comb begin
      sel_ready = 1'b0;
      case (sel)
         2'd0:    sel_ready = lane_ready[0];
         2'd1:    sel_ready = lane_ready[1];
         2'd2:    sel_ready = lane_ready[2];
         default: sel_ready = 1'b0;
      endcase
   end

   assign drain     = out_valid && sel_ready;
   assign accept    = in_valid && in_ready;
   assign last_word = (word_cnt == WORD_LAST) && (lane_cnt == 2'd2) &&
                      (group_cnt == groups_q - 8'd1);

   always_ff @(posedge clk) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:  if (start) state_nxt = (cfg_groups == 8'd0) ? DONE : RUN;
         RUN:   if (accept && last_word) state_nxt = FLUSH;
         FLUSH: if (drain) state_nxt = DONE;
         DONE:  state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      in_ready = (state == RUN) && (!out_valid || drain);
      busy     = (state == RUN) || (state == FLUSH);
      done     = (state == DONE);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         word_cnt  <= '0;
         lane_cnt  <= '0;
         group_cnt <= '0;
         groups_q  <= '0;
      end else if (state == IDLE && start) begin
         word_cnt  <= '0;
         lane_cnt  <= '0;
         group_cnt <= '0;
         groups_q  <= cfg_groups;
      end else if (accept) begin
         if (word_cnt == WORD_LAST) begin
            word_cnt <= '0;
            if (lane_cnt == 2'd2) begin
               lane_cnt  <= '0;
               group_cnt <= group_cnt + 8'd1;
            end else begin
               lane_cnt <= lane_cnt + 2'd1;
            end
         end else begin
            word_cnt <= word_cnt + 1'b1;
         end
      end
   end

   // One-entry pipeline register; accept during drain replaces the word with no bubble
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         Data_out  <= '0;
         sel       <= 2'd3;
         out_valid <= 1'b0;
      end else if (accept) begin
         Data_out  <= in_data;
         sel       <= lane_cnt;
         out_valid <= 1'b1;
      end else if (drain) begin
         sel       <= 2'd3;
         out_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_demux_dispatch_ctrl.sv
// Directed bench for demux_dispatch_ctrl: ordering, latency, backpressure, zero groups, abort.
module tb_demux_dispatch_ctrl;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start;
   logic [7:0]  cfg_groups;
   logic        in_valid;
   logic [63:0] in_data;
   logic        in_ready;
   logic [2:0]  lane_ready;
   logic [63:0] Data_out;
   logic [1:0]  sel;
   logic        out_valid;
   logic        busy;
   logic        done;

   int cyc    = 0;
   int errs   = 0;
   int checks = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   demux_dispatch_ctrl #(.DATA_W(64), .WORDS_PER_LANE(9)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .cfg_groups(cfg_groups),
      .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
      .lane_ready(lane_ready), .Data_out(Data_out), .sel(sel),
      .out_valid(out_valid), .busy(busy), .done(done)
   );

   // Streams an incrementing word sequence; stats are compared by the calling test.
   task automatic run_stream(input int groups, input int bp_after, input int mid_start,
                             output int nwords, output int seq_err, output int stall_err,
                             output int done_cnt, output int last_acc, output int done_cyc,
                             output int sel3_cyc, output int ir_cnt, output logic busy_at_done,
                             output int t0);
      int   stall_left;
      logic acc_pend;
      logic stalled;
      nwords = 0; seq_err = 0; stall_err = 0; done_cnt = 0; ir_cnt = 0;
      last_acc = -1; done_cyc = -1; sel3_cyc = -1; busy_at_done = 1'bx;
      stall_left = (bp_after >= 0) ? 5 : 0;
      acc_pend = 1'b0;
      @(negedge clk);
      start = 1'b1; cfg_groups = groups[7:0]; in_valid = 1'b1; in_data = '0;
      lane_ready = 3'b111; t0 = cyc;
      for (int i = 0; i < 400; i++) begin
         @(negedge clk);
         start = 1'b0; cfg_groups = 8'd77;
         if (mid_start > 0 && cyc == t0 + mid_start) begin
            start = 1'b1; cfg_groups = 8'd3;
         end
         if (acc_pend) in_data = in_data + 64'd1;
         acc_pend = 1'b0;
         lane_ready = 3'b111;
         stalled = 1'b0;
         if (stall_left > 0 && nwords == bp_after && out_valid) begin
            lane_ready[1] = 1'b0; stall_left--; stalled = 1'b1;
         end
         #1;
         if (stalled && (out_valid !== 1'b1 || Data_out !== 64'(nwords) ||
                         sel !== 2'd1 || in_ready !== 1'b0)) stall_err++;
         if (in_ready === 1'b1) ir_cnt++;
         if (done === 1'b1) begin
            done_cnt++;
            if (done_cyc < 0) begin done_cyc = cyc; busy_at_done = busy; end
         end
         if (sel3_cyc < 0 && last_acc >= 0 && cyc > last_acc && sel === 2'd3) sel3_cyc = cyc;
         if (out_valid === 1'b1 && lane_ready[sel] === 1'b1) begin
            if (Data_out !== 64'(nwords) || sel !== 2'((nwords / 9) % 3)) seq_err++;
            nwords++;
         end
         if (in_valid && in_ready === 1'b1) begin last_acc = cyc; acc_pend = 1'b1; end
         if (done_cyc >= 0 && cyc >= done_cyc + 3) break;
      end
      in_valid = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; start = 1'b0; cfg_groups = 8'd0; in_valid = 1'b0;
      in_data = '0; lane_ready = 3'b111;
      repeat (3) @(negedge clk);
      checks++;
      if (sel !== 2'd3 || Data_out !== 64'd0 || out_valid !== 1'b0 ||
          in_ready !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
         errs++;
         $display("FAIL reset: sel=%0d data=%0h ov=%b ir=%b busy=%b done=%b, want 3/0/0/0/0/0",
                  sel, Data_out, out_valid, in_ready, busy, done);
      end
      rst_n = 1'b1;
   endtask

   task automatic test_one_group();
      int n, se, ste, dc, la, dcy, s3, ir, t0; logic bd;
      run_stream(1, -1, 0, n, se, ste, dc, la, dcy, s3, ir, bd, t0);
      checks++; if (n !== 27) begin errs++; $display("FAIL g1_words: got %0d want 27", n); end
      checks++; if (se !== 0) begin errs++; $display("FAIL g1_order: %0d bad words want 0", se); end
      checks++; if (la - t0 !== 27) begin errs++; $display("FAIL g1_last_accept: t0+%0d want t0+27", la - t0); end
      checks++; if (dcy - t0 !== 29) begin errs++; $display("FAIL g1_done_time: t0+%0d want t0+29", dcy - t0); end
      checks++; if (s3 - t0 !== 29) begin errs++; $display("FAIL g1_sel3_time: t0+%0d want t0+29", s3 - t0); end
      checks++; if (bd !== 1'b0) begin errs++; $display("FAIL g1_busy_at_done: %b want 0", bd); end
      checks++; if (dc !== 1) begin errs++; $display("FAIL g1_done_count: %0d want 1", dc); end
   endtask

   task automatic test_backpressure();
      int n, se, ste, dc, la, dcy, s3, ir, t0; logic bd;
      run_stream(1, 11, 0, n, se, ste, dc, la, dcy, s3, ir, bd, t0);
      checks++; if (ste !== 0) begin errs++; $display("FAIL bp_stall_hold: %0d unstable cycles want 0", ste); end
      checks++; if (n !== 27 || se !== 0) begin errs++; $display("FAIL bp_stream: words=%0d bad=%0d want 27/0", n, se); end
      checks++; if (dcy - t0 !== 34) begin errs++; $display("FAIL bp_done_time: t0+%0d want t0+34", dcy - t0); end
   endtask

   task automatic test_two_groups();
      int n, se, ste, dc, la, dcy, s3, ir, t0; logic bd;
      run_stream(2, -1, 0, n, se, ste, dc, la, dcy, s3, ir, bd, t0);
      checks++; if (n !== 54) begin errs++; $display("FAIL g2_words: got %0d want 54", n); end
      checks++; if (se !== 0) begin errs++; $display("FAIL g2_order: %0d bad words want 0", se); end
      checks++; if (dc !== 1) begin errs++; $display("FAIL g2_done_count: %0d want 1", dc); end
   endtask

   task automatic test_zero_groups();
      int n, se, ste, dc, la, dcy, s3, ir, t0; logic bd;
      run_stream(0, -1, 0, n, se, ste, dc, la, dcy, s3, ir, bd, t0);
      checks++; if (dcy - t0 !== 1) begin errs++; $display("FAIL g0_done_time: t0+%0d want t0+1", dcy - t0); end
      checks++; if (ir !== 0 || n !== 0) begin errs++; $display("FAIL g0_no_transfer: ready=%0d words=%0d want 0/0", ir, n); end
      checks++; if (dc !== 1) begin errs++; $display("FAIL g0_done_count: %0d want 1", dc); end
   endtask

   task automatic test_mid_start();
      int n, se, ste, dc, la, dcy, s3, ir, t0; logic bd;
      run_stream(1, -1, 5, n, se, ste, dc, la, dcy, s3, ir, bd, t0);
      checks++; if (n !== 27 || se !== 0 || dc !== 1) begin
         errs++; $display("FAIL mid_start_ignored: words=%0d bad=%0d done=%0d want 27/0/1", n, se, dc);
      end
   endtask

   task automatic test_abort();
      int n, se, ste, dc, la, dcy, s3, ir, t0; logic bd;
      int done_seen;
      @(negedge clk);
      start = 1'b1; cfg_groups = 8'd1; in_valid = 1'b1; in_data = 64'hA0; lane_ready = 3'b111;
      repeat (10) begin
         @(negedge clk);
         start = 1'b0; in_data = in_data + 64'd1;
      end
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1; in_valid = 1'b0;
      checks++;
      if (out_valid !== 1'b0 || sel !== 2'd3 || Data_out !== 64'd0 || busy !== 1'b0 || in_ready !== 1'b0) begin
         errs++;
         $display("FAIL abort_reset: ov=%b sel=%0d data=%0h busy=%b ir=%b want 0/3/0/0/0",
                  out_valid, sel, Data_out, busy, in_ready);
      end
      done_seen = 0;
      repeat (5) begin
         @(negedge clk);
         if (done === 1'b1) done_seen++;
      end
      checks++; if (done_seen !== 0) begin errs++; $display("FAIL abort_no_done: %0d done cycles want 0", done_seen); end
      run_stream(1, -1, 0, n, se, ste, dc, la, dcy, s3, ir, bd, t0);
      checks++; if (n !== 27 || se !== 0 || dc !== 1) begin
         errs++; $display("FAIL abort_restart: words=%0d bad=%0d done=%0d want 27/0/1", n, se, dc);
      end
   endtask

   initial begin
      test_reset();
      test_one_group();
      test_backpressure();
      test_two_groups();
      test_zero_groups();
      test_mid_start();
      test_abort();
      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
